// File: rtl/btn_debounce.sv
// btn_debounce: synchronize raw push-buttons into mclk and debounce each channel independently.
// Ports: mclk (clock), reset (synchronous, active-high), btn (raw asynchronous buttons),
//        btn_level (debounced level), btn_press (accept/auto-repeat strobe),
//        btn_release (release strobe). All outputs are registered.
module btn_debounce #(
   parameter int WIDTH         = 3,
   parameter int DB_CYCLES     = 500000,
   parameter int REPEAT_CYCLES = 0
) (
   input  logic             mclk,
   input  logic             reset,
   input  logic [WIDTH-1:0] btn,
   output logic [WIDTH-1:0] btn_level,
   output logic [WIDTH-1:0] btn_press,
   output logic [WIDTH-1:0] btn_release
);
   localparam int DCW = $clog2(DB_CYCLES + 1) > 1 ? $clog2(DB_CYCLES + 1) : 1;
   localparam int RCW = $clog2(REPEAT_CYCLES + 1) > 1 ? $clog2(REPEAT_CYCLES + 1) : 1;
   localparam logic [DCW-1:0] DC_LAST = DCW'(DB_CYCLES > 1 ? DB_CYCLES - 2 : 0);
   localparam logic [RCW-1:0] RC_LAST = RCW'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);
   localparam logic [1:0] RELEASED   = 2'd0;
   localparam logic [1:0] PRESS_PEND = 2'd1;
   localparam logic [1:0] PRESSED    = 2'd2;
   localparam logic [1:0] REL_PEND   = 2'd3;
   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_level;
   logic [WIDTH-1:0] r_press;
   logic [WIDTH-1:0] r_release;
   logic [1:0]       r_st [WIDTH];
   logic [DCW-1:0]   r_dc [WIDTH];
   logic [RCW-1:0]   r_rc [WIDTH];
   // The pending states count DB_CYCLES-1 agreeing edges; with DB_CYCLES=1 the
   // stable states accept directly, so the pending states are never entered.
   always_ff @(posedge mclk) begin
      if (reset) begin
         r_s1      <= '0;
         r_s2      <= '0;
         r_level   <= '0;
         r_press   <= '0;
         r_release <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            r_st[i] <= RELEASED;
            r_dc[i] <= '0;
            r_rc[i] <= '0;
         end
      end else begin
         r_s1      <= btn;
         r_s2      <= r_s1;
         r_press   <= '0;
         r_release <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            case (r_st[i])
               RELEASED:
                  if (r_s2[i] && DB_CYCLES == 1) begin
                     r_st[i]    <= PRESSED;
                     r_level[i] <= 1'b1;
                     r_press[i] <= 1'b1;
                     r_rc[i]    <= '0;
                  end else if (r_s2[i]) begin
                     r_st[i] <= PRESS_PEND;
                     r_dc[i] <= '0;
                  end
               PRESS_PEND:
                  if (!r_s2[i]) begin
                     r_st[i] <= RELEASED;
                     r_dc[i] <= '0;
                  end else if (r_dc[i] == DC_LAST) begin
                     r_st[i]    <= PRESSED;
                     r_level[i] <= 1'b1;
                     r_press[i] <= 1'b1;
                     r_dc[i]    <= '0;
                     r_rc[i]    <= '0;
                  end else begin
                     r_dc[i] <= r_dc[i] + DCW'(1);
                  end
               PRESSED:
                  if (!r_s2[i] && DB_CYCLES == 1) begin
                     r_st[i]      <= RELEASED;
                     r_level[i]   <= 1'b0;
                     r_release[i] <= 1'b1;
                     r_rc[i]      <= '0;
                  end else if (!r_s2[i]) begin
                     r_st[i] <= REL_PEND;
                     r_dc[i] <= '0;
                     r_rc[i] <= '0;
                  end else if (REPEAT_CYCLES > 0 && r_rc[i] == RC_LAST) begin
                     r_press[i] <= 1'b1;
                     r_rc[i]    <= '0;
                  end else if (REPEAT_CYCLES > 0) begin
                     r_rc[i] <= r_rc[i] + RCW'(1);
                  end
               REL_PEND:
                  if (r_s2[i]) begin
                     r_st[i] <= PRESSED;
                     r_dc[i] <= '0;
                     r_rc[i] <= '0;
                  end else if (r_dc[i] == DC_LAST) begin
                     r_st[i]      <= RELEASED;
                     r_level[i]   <= 1'b0;
                     r_release[i] <= 1'b1;
                     r_dc[i]      <= '0;
                  end else begin
                     r_dc[i] <= r_dc[i] + DCW'(1);
                  end
               default:
                  r_st[i] <= RELEASED;
            endcase
         end
      end
   end
   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: scoreboard bench for btn_debounce over three parameter sets
module tb_btn_debounce;
   typedef struct {
      int         dut;
      int         at;
      logic [2:0] p;
      logic [2:0] r;
   } ev_t;
   logic       clk = 1'b0;
   int         edge_n = 0;
   int         checks = 0;
   int         errors = 0;
   ev_t        sb[$];
   logic       rst_a, rst_b, rst_c;
   logic [2:0] a_btn, a_level, a_press, a_rel;
   logic [2:0] b_btn, b_level, b_press, b_rel;
   logic [2:0] c_btn, c_level, c_press, c_rel;
   logic [2:0] m_ep, m_er, m_ap, m_ar;
   logic [7:0] seq;
   int         e0, a0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   btn_debounce #(.WIDTH(3), .DB_CYCLES(4), .REPEAT_CYCLES(0)) u_a (
      .mclk(clk), .reset(rst_a), .btn(a_btn),
      .btn_level(a_level), .btn_press(a_press), .btn_release(a_rel));
   btn_debounce #(.WIDTH(3), .DB_CYCLES(4), .REPEAT_CYCLES(8)) u_b (
      .mclk(clk), .reset(rst_b), .btn(b_btn),
      .btn_level(b_level), .btn_press(b_press), .btn_release(b_rel));
   btn_debounce #(.WIDTH(3), .DB_CYCLES(1), .REPEAT_CYCLES(0)) u_c (
      .mclk(clk), .reset(rst_c), .btn(c_btn),
      .btn_level(c_level), .btn_press(c_press), .btn_release(c_rel));

   task automatic push(input int dut, input int at, input logic [2:0] p, input logic [2:0] r);
      sb.push_back('{dut, at, p, r});
   endtask

   task automatic wait_to(input int target);
      while (edge_n < target) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s edge %0d got %b expected %b", tag, edge_n, got, exp);
      end
   endtask

   // Every edge, each DUT's strobes must equal exactly the events scheduled for that edge.
   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 3; d++) begin
         m_ep = '0;
         m_er = '0;
         for (int k = sb.size() - 1; k >= 0; k--)
            if (sb[k].dut == d && sb[k].at == edge_n) begin
               m_ep = m_ep | sb[k].p;
               m_er = m_er | sb[k].r;
               sb.delete(k);
            end
         m_ap = d == 0 ? a_press : d == 1 ? b_press : c_press;
         m_ar = d == 0 ? a_rel : d == 1 ? b_rel : c_rel;
         checks++;
         assert ({m_ap, m_ar} === {m_ep, m_er}) else begin
            errors++;
            $error("FAIL strobe dut%0d edge %0d got press %b release %b expected press %b release %b",
                   d, edge_n, m_ap, m_ar, m_ep, m_er);
         end
      end
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      a_btn = 3'b111; b_btn = 3'b000; c_btn = 3'b000;
      seq = 8'b1110_1101;
      // reset held three edges with all buttons of u_a pressed
      wait_to(1);
      chk("rst_level_a", a_level, 3'b000);
      chk("rst_level_b", b_level, 3'b000);
      chk("rst_level_c", c_level, 3'b000);
      wait_to(3);
      chk("rst_hold_a", a_level, 3'b000);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      push(0, 9, 3'b111, 3'b000);
      wait_to(8);
      chk("t1_pre", a_level, 3'b000);
      wait_to(9);
      chk("t1_press", a_level, 3'b111);
      wait_to(14);
      chk("t1_hold", a_level, 3'b111);
      a_btn = 3'b000;
      push(0, 20, 3'b000, 3'b111);
      wait_to(20);
      chk("t1_rel", a_level, 3'b000);
      // clean press and release on channel 0
      wait_to(24);
      e0 = edge_n + 1;
      a_btn = 3'b001;
      push(0, e0 + 5, 3'b001, 3'b000);
      wait_to(e0 + 4);
      chk("t2_pre", a_level, 3'b000);
      wait_to(e0 + 5);
      chk("t2_press", a_level, 3'b001);
      wait_to(e0 + 19);
      a_btn = 3'b000;
      push(0, e0 + 25, 3'b000, 3'b001);
      wait_to(e0 + 24);
      chk("t2_hold", a_level, 3'b001);
      wait_to(e0 + 25);
      chk("t2_rel", a_level, 3'b000);
      // bounce on channel 1, settling high
      wait_to(e0 + 30);
      e0 = edge_n + 1;
      push(0, e0 + 10, 3'b010, 3'b000);
      for (int k = 0; k < 8; k++) begin
         a_btn[1] = seq[k];
         @(negedge clk);
      end
      wait_to(e0 + 9);
      chk("t3_pre", a_level, 3'b000);
      wait_to(e0 + 10);
      chk("t3_press", a_level, 3'b010);
      wait_to(e0 + 14);
      a_btn = 3'b000;
      push(0, e0 + 20, 3'b000, 3'b010);
      wait_to(e0 + 20);
      chk("t3_rel", a_level, 3'b000);
      // reset while channel 0 is held and accepted
      wait_to(e0 + 24);
      e0 = edge_n + 1;
      a_btn = 3'b001;
      push(0, e0 + 5, 3'b001, 3'b000);
      wait_to(e0 + 8);
      chk("t5_held", a_level, 3'b001);
      rst_a = 1'b1;
      wait_to(e0 + 9);
      rst_a = 1'b0;
      chk("t5_rst", a_level, 3'b000);
      push(0, e0 + 15, 3'b001, 3'b000);
      wait_to(e0 + 14);
      chk("t5_requal", a_level, 3'b000);
      wait_to(e0 + 15);
      chk("t5_press", a_level, 3'b001);
      e0 = edge_n + 1;
      a_btn = 3'b000;
      push(0, e0 + 5, 3'b000, 3'b001);
      wait_to(e0 + 5);
      chk("t5_rel", a_level, 3'b000);
      // auto-repeat every 8 cycles on channel 2 with a one-cycle dropout
      wait_to(e0 + 8);
      e0 = edge_n + 1;
      a0 = e0 + 5;
      b_btn = 3'b100;
      push(1, a0, 3'b100, 3'b000);
      push(1, a0 + 8, 3'b100, 3'b000);
      push(1, a0 + 16, 3'b100, 3'b000);
      push(1, a0 + 24, 3'b100, 3'b000);
      wait_to(a0);
      chk("t4_press", b_level, 3'b100);
      wait_to(a0 + 27);
      b_btn = 3'b000;
      wait_to(a0 + 28);
      b_btn = 3'b100;
      push(1, a0 + 39, 3'b100, 3'b000);
      wait_to(a0 + 30);
      chk("t4_glitch", b_level, 3'b100);
      wait_to(a0 + 31);
      chk("t4_back", b_level, 3'b100);
      wait_to(a0 + 43);
      b_btn = 3'b000;
      push(1, a0 + 49, 3'b000, 3'b100);
      wait_to(a0 + 48);
      chk("t4_hold", b_level, 3'b100);
      wait_to(a0 + 49);
      chk("t4_rel", b_level, 3'b000);
      // single-cycle pulse with DB_CYCLES=1
      wait_to(a0 + 52);
      e0 = edge_n + 1;
      c_btn = 3'b001;
      push(2, e0 + 2, 3'b001, 3'b000);
      push(2, e0 + 3, 3'b000, 3'b001);
      wait_to(e0);
      c_btn = 3'b000;
      wait_to(e0 + 1);
      chk("t6_pre", c_level, 3'b000);
      wait_to(e0 + 2);
      chk("t6_press", c_level, 3'b001);
      wait_to(e0 + 3);
      chk("t6_rel", c_level, 3'b000);
      wait_to(e0 + 8);
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
